// File: rtl/cache_writeback_dm.sv
// Direct-mapped write-back / write-allocate data cache (4 lines x 16 B) with a 1 KiB byte memory.
// Define CACHE_WRITE_THROUGH_EN to build the write-through variant instead.

module cache_writeback_dm_mem (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [5:0]   i_rd_line_addr,
    output logic [127:0] o_rd_line,
    input  logic         i_wb_en,
    input  logic [5:0]   i_wb_line_addr,
    input  logic [127:0] i_wb_line,
    input  logic         i_wt_en,
    input  logic [7:0]   i_wt_word_addr,
    input  logic [31:0]  i_wt_word
);
    logic [7:0] Memory [0:1023];

    // Little-endian: byte b of the line sits at bits [8b+7:8b].
    always_comb begin
        o_rd_line = '0;
        for (int b = 0; b < 16; b++)
            o_rd_line[8*b +: 8] = Memory[{i_rd_line_addr, 4'(b)}];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 1024; i++)
                Memory[i] <= 8'h00;
        end else begin
            if (i_wb_en)
                for (int b = 0; b < 16; b++)
                    Memory[{i_wb_line_addr, 4'(b)}] <= i_wb_line[8*b +: 8];
            if (i_wt_en)
                for (int b = 0; b < 4; b++)
                    Memory[{i_wt_word_addr, 2'(b)}] <= i_wt_word[8*b +: 8];
        end
    end
endmodule

module cache_writeback_dm (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        read_write,
    input  logic [9:0]  address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        hit_miss
);
    logic        r_valid [0:3];
    logic        r_dirty [0:3];
    logic [3:0]  r_tag   [0:3];
    logic [31:0] r_data  [0:3][0:3];

    logic [3:0]   w_tag;
    logic [1:0]   w_idx;
    logic [1:0]   w_word;
    logic         w_hit;
    logic [127:0] w_mem_line;
    logic [127:0] w_victim_line;
    logic         w_wb_en;
    logic         w_wt_en;
    logic         w_set_dirty;
    logic         w_unused;

    assign w_tag    = address[9:6];
    assign w_idx    = address[5:4];
    assign w_word   = address[3:2];
    assign w_unused = ^address[1:0];

    assign w_hit    = rst_n && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign hit_miss = w_hit;

    assign w_victim_line = {r_data[w_idx][3], r_data[w_idx][2], r_data[w_idx][1], r_data[w_idx][0]};

    always_comb begin
        read_data = 32'h0;
        if (rst_n)
            read_data = w_hit ? r_data[w_idx][w_word] : w_mem_line[32*w_word +: 32];
    end

`ifdef CACHE_WRITE_THROUGH_EN
    assign w_wb_en     = 1'b0;
    assign w_wt_en     = rst_n && read_write;
    assign w_set_dirty = 1'b0;
`else
    assign w_wb_en     = rst_n && !w_hit && r_valid[w_idx] && r_dirty[w_idx];
    assign w_wt_en     = 1'b0;
    assign w_set_dirty = read_write;
`endif

    cache_writeback_dm_mem mem (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rd_line_addr (address[9:4]),
        .o_rd_line      (w_mem_line),
        .i_wb_en        (w_wb_en),
        .i_wb_line_addr ({r_tag[w_idx], w_idx}),
        .i_wb_line      (w_victim_line),
        .i_wt_en        (w_wt_en),
        .i_wt_word_addr (address[9:2]),
        .i_wt_word      (write_data)
    );

    // A write miss refills then merges the store word; the later NBA wins for that word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int l = 0; l < 4; l++) begin
                r_valid[l] <= 1'b0;
                r_dirty[l] <= 1'b0;
                r_tag[l]   <= 4'h0;
                for (int w = 0; w < 4; w++)
                    r_data[l][w] <= 32'h0;
            end
        end else begin
            if (!w_hit) begin
                for (int w = 0; w < 4; w++)
                    r_data[w_idx][w] <= w_mem_line[32*w +: 32];
                r_valid[w_idx] <= 1'b1;
                r_tag[w_idx]   <= w_tag;
                r_dirty[w_idx] <= w_set_dirty;
            end else if (w_set_dirty) begin
                r_dirty[w_idx] <= 1'b1;
            end
            if (read_write)
                r_data[w_idx][w_word] <= write_data;
        end
    end
endmodule

// File: tb/tb_cache_writeback_dm.sv
// Directed bench for cache_writeback_dm; expectations follow CACHE_WRITE_THROUGH_EN when defined.

module tb_cache_writeback_dm;
    logic        clk;
    logic        rst_n;
    logic        read_write;
    logic [9:0]  address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        hit_miss;

    int n_checks = 0;
    int n_fail   = 0;

    cache_writeback_dm dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .read_write (read_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .hit_miss   (hit_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic mem_byte(input string tag, input int a, input logic [7:0] exp);
        check(tag, {24'h0, dut.mem.Memory[a]}, {24'h0, exp});
    endtask

    // Apply one request, check outputs before the edge, then step past the edge.
    task automatic req(input string tag, input logic rw, input logic [9:0] a, input logic [31:0] wd,
                       input logic exp_hit, input logic chk_rd, input logic [31:0] exp_rd);
        read_write = rw;
        address    = a;
        write_data = wd;
        #2;
        check({tag, "_hit"}, {31'h0, hit_miss}, {31'h0, exp_hit});
        if (chk_rd) check({tag, "_rd"}, read_data, exp_rd);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] exp_b0;
        rst_n = 1'b0; read_write = 1'b0; address = 10'h000; write_data = 32'h0;
        @(posedge clk); @(posedge clk); #1;
        check("rst_hit", {31'h0, hit_miss}, 32'h0);
        check("rst_rd", read_data, 32'h0);
        mem_byte("rst_mem0", 0, 8'h00);
        rst_n = 1'b1;

        req("r000_cold",  1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 32'h0);
        req("r000_again", 1'b0, 10'h000, 32'h0,        1'b1, 1'b1, 32'h0);
        req("w000",       1'b1, 10'h000, 32'h000000FF, 1'b1, 1'b0, 32'h0);
        req("r000_ff",    1'b0, 10'h000, 32'h0,        1'b1, 1'b1, 32'h000000FF);
`ifdef CACHE_WRITE_THROUGH_EN
        exp_b0 = 8'hFF;
`else
        exp_b0 = 8'h00;
`endif
        mem_byte("mem0_after_w", 0, exp_b0);
        mem_byte("mem1_after_w", 1, 8'h00);

        req("r200_evict", 1'b0, 10'h200, 32'h0,        1'b0, 1'b1, 32'h0);
        mem_byte("mem0_after_evict", 0, 8'hFF);
        req("r000_refill",1'b0, 10'h000, 32'h0,        1'b0, 1'b1, 32'h000000FF);
        req("r300",       1'b0, 10'h300, 32'h0,        1'b0, 1'b1, 32'h0);
        req("r200",       1'b0, 10'h200, 32'h0,        1'b0, 1'b1, 32'h0);
        mem_byte("wrap_mem0", 0, 8'hFF);
        mem_byte("wrap_mem1", 1, 8'h00);
        mem_byte("wrap_mem2", 2, 8'h00);
        mem_byte("wrap_mem3", 3, 8'h00);

        req("w044_alloc", 1'b1, 10'h044, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        req("r044",       1'b0, 10'h044, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF);
        req("r040_merge", 1'b0, 10'h040, 32'h0,        1'b1, 1'b1, 32'h0);
`ifdef CACHE_WRITE_THROUGH_EN
        exp_b0 = 8'hEF;
`else
        exp_b0 = 8'h00;
`endif
        mem_byte("mem44_before_evict", 'h44, exp_b0);
        req("r3c4_evict", 1'b0, 10'h3C4, 32'h0,        1'b0, 1'b1, 32'h0);
        mem_byte("mem44", 'h44, 8'hEF);
        mem_byte("mem45", 'h45, 8'hBE);
        mem_byte("mem46", 'h46, 8'hAD);
        mem_byte("mem47", 'h47, 8'hDE);

        req("w010_alloc", 1'b1, 10'h010, 32'h12345678, 1'b0, 1'b0, 32'h0);
        req("w010_hit",   1'b1, 10'h010, 32'h9ABCDEF0, 1'b1, 1'b0, 32'h0);
        rst_n = 1'b0; read_write = 1'b1; address = 10'h010; write_data = 32'hAAAAAAAA;
        #2;
        check("midrst_hit", {31'h0, hit_miss}, 32'h0);
        check("midrst_rd", read_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        req("r010_after_rst", 1'b0, 10'h010, 32'h0,    1'b0, 1'b1, 32'h0);
        mem_byte("mem10_after_rst", 'h10, 8'h00);
        mem_byte("mem44_after_rst", 'h44, 8'h00);
        req("r010_hit_after_rst", 1'b0, 10'h010, 32'h0, 1'b1, 1'b1, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
